// File: rtl/dl_reg_pipe.sv
// ---------------------------------------------------------------------------
// dl_reg_pipe: multi-stage pipeline register with per-stage valid bits and a
// valid/ready handshake. Supports backpressure, bubble collapsing, a
// synchronous flush and an occupancy count.
//
// Parameters:
//   NUM_BITS   payload width (>=1)
//   NUM_STAGES number of register stages (>=1), sets fill latency
//   RESET_VAL  payload reset/clear value (used only with the option below)
//   CNT_BITS   derived occupancy-count width (not overridable)
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   flush             synchronous kill of all in-flight entries
//   in_val/in_rdy     upstream handshake, in_data payload
//   out_val/out_rdy   downstream handshake, out_data payload
//   count             number of valid stages, 0..NUM_STAGES
//
// Optional feature macro: DL_REG_PIPE_CLR_DATA_EN
//   defined   : data regs reset/clear to RESET_VAL, out_data=RESET_VAL
//               whenever out_val=0
//   undefined : data regs have no reset/clear; out_data undefined when
//               out_val=0
// ---------------------------------------------------------------------------
module dl_reg_pipe #(
    parameter int unsigned          NUM_BITS   = 32,
    parameter int unsigned          NUM_STAGES = 2,
    parameter logic [NUM_BITS-1:0]  RESET_VAL  = '0,
    localparam int unsigned         CNT_BITS   = $clog2(NUM_STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [NUM_BITS-1:0] out_data,
    output logic [CNT_BITS-1:0] count
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] v;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] free;
    logic [NUM_STAGES-1:0] load_v;
    logic [NUM_BITS-1:0]   d      [NUM_STAGES];
    logic [NUM_BITS-1:0]   load_d [NUM_STAGES];
    logic                  acc;
    logic                  drain;

    // Advance/free chain, resolved from the output side backwards so a
    // stage counts as free when its occupant moves on this same cycle.
    always_comb begin
        adv        = '0;
        free       = '0;
        adv[LAST]  = v[LAST] & out_rdy;
        free[LAST] = ~v[LAST] | adv[LAST];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            adv[i]  = v[i] & free[i+1];
            free[i] = ~v[i] | adv[i];
        end
    end

    assign in_rdy  = free[0] & ~flush;
    assign acc     = in_val & in_rdy;
    assign out_val = v[LAST] & ~flush;
    assign drain   = out_val & out_rdy;

    // What each stage would capture if it is free this cycle.
    always_comb begin
        load_v    = '0;
        load_v[0] = acc;
        load_d[0] = in_data;
        for (int i = 1; i < NUM_STAGES; i++) begin
            load_v[i] = adv[i-1];
            load_d[i] = d[i-1];
        end
    end

    // Valid bits and occupancy count; an empty stage always loads, which
    // collapses bubbles toward the output end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            count <= '0;
        end else if (flush) begin
            v     <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (free[i]) begin
                    v[i] <= load_v[i];
                end
            end
            count <= count + CNT_BITS'(acc) - CNT_BITS'(drain);
        end
    end

`ifdef DL_REG_PIPE_CLR_DATA_EN
    // Data regs reset and clear to RESET_VAL; a stage that drains without
    // refill returns to RESET_VAL so idle outputs are deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                d[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (free[i]) begin
                    d[i] <= load_v[i] ? load_d[i] : RESET_VAL;
                end
            end
        end
    end

    // Flush masks out_val in its cycle, so present RESET_VAL then as well.
    assign out_data = flush ? RESET_VAL : d[LAST];
`else
    // Data regs carry no reset and only capture when a valid entry arrives.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (free[i] && load_v[i]) begin
                d[i] <= load_d[i];
            end
        end
    end

    assign out_data = d[LAST];

    logic unused_reset_val;
    assign unused_reset_val = ^RESET_VAL;
`endif

`ifndef SYNTHESIS
    // Occupancy count must always equal the number of valid stages.
    count_matches_valid : assert property (
        @(posedge clk) disable iff (!rst_n)
        count == CNT_BITS'($countones(v))
    );
`endif

endmodule

// File: tb/tb_dl_reg_pipe.sv
module tb_dl_reg_pipe;

    localparam int unsigned NB = 8;
    localparam int unsigned NS = 3;
    localparam int unsigned CB = $clog2(NS + 1);
    localparam logic [NB-1:0] RV = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in_data;
    logic          out_val;
    logic          out_rdy;
    logic [NB-1:0] out_data;
    logic [CB-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    dl_reg_pipe #(
        .NUM_BITS   (NB),
        .NUM_STAGES (NS),
        .RESET_VAL  (RV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of accepted words with their age in edges.
    // The head is visible once it has aged NS-1 edges; the input is
    // blocked only when all NS slots are held and nothing drains.
    logic [NB-1:0] mq_d[$];
    int            mq_a[$];

    function automatic logic m_out_val();
        return !flush && mq_d.size() > 0 && mq_a[0] >= int'(NS) - 1;
    endfunction

    function automatic logic m_in_rdy();
        return !flush && (mq_d.size() < int'(NS) || out_rdy);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_d.delete();
            mq_a.delete();
        end else if (flush) begin
            mq_d.delete();
            mq_a.delete();
        end else begin
            logic mo, mi;
            mo = m_out_val();
            mi = m_in_rdy();
            if (mo && out_rdy) begin
                void'(mq_d.pop_front());
                void'(mq_a.pop_front());
            end
            for (int i = 0; i < mq_a.size(); i++) mq_a[i] = mq_a[i] + 1;
            if (in_val && mi) begin
                mq_d.push_back(in_data);
                mq_a.push_back(0);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic mo;
        mo = m_out_val();
        chk("cyc_out_val", 32'(out_val), 32'(mo));
        chk("cyc_in_rdy", 32'(in_rdy), 32'(m_in_rdy()));
        chk("cyc_count", 32'(count), 32'(mq_d.size()));
        if (mo) chk("cyc_out_data", 32'(out_data), 32'(mq_d[0]));
`ifdef DL_REG_PIPE_CLR_DATA_EN
        else chk("cyc_idle_data", 32'(out_data), 32'(RV));
`endif
    end

    task automatic set(input logic v, input logic [NB-1:0] dat, input logic r, input logic f);
        in_val  = v;
        in_data = dat;
        out_rdy = r;
        flush   = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        // Reset then idle
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
`ifdef DL_REG_PIPE_CLR_DATA_EN
        chk("rst_out_data", 32'(out_data), 32'h00);
`endif
        tick();

        // Back-to-back stream
        set(1'b1, 8'h11, 1'b1, 1'b0); tick();
        chk("str_lat_not_yet", 32'(out_val), 32'd0);
        set(1'b1, 8'h22, 1'b1, 1'b0); tick();
        set(1'b1, 8'h33, 1'b1, 1'b0); tick();
        chk("str_first_val", 32'(out_val), 32'd1);
        chk("str_first_data", 32'(out_data), 32'h11);
        chk("str_peak_count", 32'(count), 32'd3);
        set(1'b0, 8'h00, 1'b1, 1'b0); tick();
        chk("str_second_data", 32'(out_data), 32'h22);
        tick();
        chk("str_third_data", 32'(out_data), 32'h33);
        tick();
        chk("str_empty", 32'(count), 32'd0);

        // Fill with backpressure, then simultaneous drain and accept
        set(1'b1, 8'h11, 1'b0, 1'b0); tick();
        set(1'b1, 8'h22, 1'b0, 1'b0); tick();
        set(1'b1, 8'h33, 1'b0, 1'b0); tick();
        set(1'b1, 8'h44, 1'b0, 1'b0); #1;
        chk("full_count", 32'(count), 32'd3);
        chk("full_in_rdy", 32'(in_rdy), 32'd0);
        chk("full_data", 32'(out_data), 32'h11);
        tick();
        chk("full_frozen", 32'(out_data), 32'h11);
        set(1'b1, 8'h44, 1'b1, 1'b0); #1;
        chk("full_pass_rdy", 32'(in_rdy), 32'd1);
        tick();
        chk("full_pass_count", 32'(count), 32'd3);
        chk("full_pass_data", 32'(out_data), 32'h22);
        set(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        chk("full_drained", 32'(count), 32'd0);

        // Bubble collapse
        set(1'b1, 8'hA1, 1'b0, 1'b0); tick();
        set(1'b0, 8'h00, 1'b0, 1'b0); tick();
        set(1'b1, 8'hA2, 1'b0, 1'b0); tick();
        set(1'b0, 8'h00, 1'b0, 1'b0); tick(); tick();
        chk("bub_count", 32'(count), 32'd2);
        chk("bub_head", 32'(out_data), 32'hA1);
        set(1'b0, 8'h00, 1'b1, 1'b0); tick();
        chk("bub_second_val", 32'(out_val), 32'd1);
        chk("bub_second", 32'(out_data), 32'hA2);
        tick();
        chk("bub_empty", 32'(out_val), 32'd0);

        // Flush with traffic in flight
        set(1'b1, 8'hB1, 1'b0, 1'b0); tick();
        set(1'b1, 8'hB2, 1'b0, 1'b0); tick();
        set(1'b1, 8'hB3, 1'b1, 1'b1); #1;
        chk("fl_in_rdy", 32'(in_rdy), 32'd0);
        chk("fl_out_val", 32'(out_val), 32'd0);
        tick();
        chk("fl_count", 32'(count), 32'd0);
        tick(); tick();
        chk("fl_held", 32'(count), 32'd0);
        set(1'b0, 8'h00, 1'b1, 1'b0); tick();
        chk("fl_after", 32'(out_val), 32'd0);

        // Async reset mid-stall
        set(1'b1, 8'h01, 1'b0, 1'b0); tick();
        set(1'b1, 8'h02, 1'b0, 1'b0); tick();
        set(1'b1, 8'h03, 1'b0, 1'b0); tick();
        set(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ar_pre_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_val", 32'(out_val), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        tick();
        rst_n = 1'b1;
        set(1'b1, 8'h55, 1'b1, 1'b0); tick();
        set(1'b0, 8'h00, 1'b1, 1'b0); tick();
        chk("ar_lat_not_yet", 32'(out_val), 32'd0);
        tick();
        chk("ar_post_val", 32'(out_val), 32'd1);
        chk("ar_post_data", 32'(out_data), 32'h55);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
